// File: rtl/pipeline_types.sv
// -----------------------------------------------------------------------------
// pipeline_types
//   Shared bus typedefs and constants for the fetch path.
//   Holds the refill FSM state encoding used by line_fill_responder, the
//   cache-line geometry (words per line, byte-offset width) and the common
//   32/256-bit bus types.
// -----------------------------------------------------------------------------
package pipeline_types;

  typedef logic [31:0]  bus32_t;
  typedef logic [255:0] bus256_t;

  // Cache-line geometry: 8 words of 32 bits, 32-byte aligned.
  localparam int LINE_WORDS    = 8;
  localparam int LINE_OFFSET_W = 5;

  // Refill responder FSM states.
  typedef enum logic [2:0] {
    FS_IDLE   = 3'd0,
    FS_L_REQ  = 3'd1,
    FS_L_WAIT = 3'd2,
    FS_L_RESP = 3'd3,
    FS_U_REQ  = 3'd4,
    FS_U_WAIT = 3'd5,
    FS_U_RESP = 3'd6
  } fill_state_t;

endpackage

// File: rtl/line_fill_responder.sv
// -----------------------------------------------------------------------------
// line_fill_responder
//   Memory-side responder for the icache refill interface. A line request is
//   served as eight sequential single-word reads on a request/grant/response
//   memory port; the words are gathered in a fill buffer and returned as one
//   256-bit line with a one-cycle ret_valid pulse. An uncached request is a
//   single read returned with a one-cycle uncache_valid pulse. Only one memory
//   read is ever outstanding; line requests win over uncached requests.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   rd_req / rd_addr         line refill request (held until ret_valid)
//   ret_valid / ret_data     completed line, word i at [32*i +: 32]
//   uncache_en/uncache_addr  uncached word request (held until uncache_valid)
//   uncache_valid/_inst      completed uncached word
//   mem_req / mem_addr       word read request towards instruction memory
//   mem_gnt                  request accepted this cycle
//   mem_rvalid / mem_rdata   read response
// -----------------------------------------------------------------------------
module line_fill_responder
  import pipeline_types::*;
#(
  parameter int LINE_WORDS = 8,
  parameter int ADDR_W     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              ret_valid,
  output logic [255:0]      ret_data,
  input  logic              uncache_en,
  input  logic [ADDR_W-1:0] uncache_addr,
  output logic              uncache_valid,
  output logic [31:0]       uncache_inst,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata
);

  localparam int CNT_W = $clog2(LINE_WORDS);
  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(LINE_WORDS - 1);

  fill_state_t       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  // Holds the line base for refills, or the full word address for uncached
  // reads; the two never overlap in time.
  logic [ADDR_W-1:0] addr_q, addr_d;
  bus32_t            fill_q [LINE_WORDS];
  bus32_t            fill_d [LINE_WORDS];
  bus256_t           ret_data_q, ret_data_d;
  bus32_t            uncache_inst_q, uncache_inst_d;
  bus256_t           line_next;

  // Byte-offset bits of the refill address are deliberately discarded.
  logic unused_offset;
  assign unused_offset = ^rd_addr[LINE_OFFSET_W-1:0];

  // The line presented at completion includes the word being written in the
  // same cycle, so it is packed from the next-state fill buffer.
  for (genvar gi = 0; gi < LINE_WORDS; gi++) begin : g_pack
    assign line_next[32*gi +: 32] = fill_d[gi];
  end

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    addr_d         = addr_q;
    fill_d         = fill_q;
    ret_data_d     = ret_data_q;
    uncache_inst_d = uncache_inst_q;

    case (state_q)
      FS_IDLE: begin
        if (rd_req) begin
          addr_d  = {rd_addr[ADDR_W-1:LINE_OFFSET_W], {LINE_OFFSET_W{1'b0}}};
          cnt_d   = '0;
          state_d = FS_L_REQ;
        end else if (uncache_en) begin
          addr_d  = uncache_addr;
          state_d = FS_U_REQ;
        end
      end
      FS_L_REQ: begin
        if (mem_gnt) state_d = FS_L_WAIT;
      end
      FS_L_WAIT: begin
        if (mem_rvalid) begin
          fill_d[cnt_q] = mem_rdata;
          // Exit on the last word rather than letting the counter wrap.
          if (cnt_q == LAST_WORD) begin
            ret_data_d = line_next;
            state_d    = FS_L_RESP;
          end else begin
            cnt_d   = cnt_q + 1'b1;
            state_d = FS_L_REQ;
          end
        end
      end
      FS_L_RESP: begin
        state_d = FS_IDLE;
      end
      FS_U_REQ: begin
        if (mem_gnt) state_d = FS_U_WAIT;
      end
      FS_U_WAIT: begin
        if (mem_rvalid) begin
          uncache_inst_d = mem_rdata;
          state_d        = FS_U_RESP;
        end
      end
      FS_U_RESP: begin
        state_d = FS_IDLE;
      end
      default: begin
        state_d = FS_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= FS_IDLE;
      cnt_q          <= '0;
      addr_q         <= '0;
      fill_q         <= '{default: '0};
      ret_data_q     <= '0;
      uncache_inst_q <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      addr_q         <= addr_d;
      fill_q         <= fill_d;
      ret_data_q     <= ret_data_d;
      uncache_inst_q <= uncache_inst_d;
    end
  end

  // Line base is 32-byte aligned, so the word index drops straight into the
  // offset field with no carry into the upper address bits.
  always_comb begin
    mem_addr = '0;
    case (state_q)
      FS_L_REQ: mem_addr = {addr_q[ADDR_W-1:LINE_OFFSET_W], cnt_q,
                            {(LINE_OFFSET_W - CNT_W){1'b0}}};
      FS_U_REQ: mem_addr = addr_q;
      default:  mem_addr = '0;
    endcase
  end

  assign mem_req       = (state_q == FS_L_REQ) || (state_q == FS_U_REQ);
  assign ret_valid     = (state_q == FS_L_RESP);
  assign uncache_valid = (state_q == FS_U_RESP);
  assign ret_data      = ret_data_q;
  assign uncache_inst  = uncache_inst_q;

endmodule

// File: tb/tb_line_fill_responder.sv
// -----------------------------------------------------------------------------
// tb_line_fill_responder
//   Directed bench for line_fill_responder. Stimulus pushes expected responses
//   (kind, data, completion cycle) and expected memory addresses into queues;
//   a monitor checks every valid pulse and a memory model checks every
//   request address while serving reads.
// -----------------------------------------------------------------------------
module tb_line_fill_responder;

  logic         clk = 1'b0;
  logic         rst;
  logic         rd_req;
  logic [31:0]  rd_addr;
  logic         ret_valid;
  logic [255:0] ret_data;
  logic         uncache_en;
  logic [31:0]  uncache_addr;
  logic         uncache_valid;
  logic [31:0]  uncache_inst;
  logic         mem_req;
  logic [31:0]  mem_addr;
  logic         mem_gnt;
  logic         mem_rvalid;
  logic [31:0]  mem_rdata;

  line_fill_responder #(.LINE_WORDS(8), .ADDR_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .rd_req       (rd_req),
    .rd_addr      (rd_addr),
    .ret_valid    (ret_valid),
    .ret_data     (ret_data),
    .uncache_en   (uncache_en),
    .uncache_addr (uncache_addr),
    .uncache_valid(uncache_valid),
    .uncache_inst (uncache_inst),
    .mem_req      (mem_req),
    .mem_addr     (mem_addr),
    .mem_gnt      (mem_gnt),
    .mem_rvalid   (mem_rvalid),
    .mem_rdata    (mem_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit           is_unc;
    logic [255:0] data;
    int           cyc;
    string        name;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] addr_q[$];

  int n_cmp  = 0;
  int n_fail = 0;

  // Memory model controls
  bit          spur_all   = 1'b0;
  int          stall_left = 0;
  logic [31:0] stall_addr = 32'h0;
  bit          pend       = 1'b0;
  logic [31:0] pend_addr  = 32'h0;
  int          rv_count   = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[7:0], a[31:8]} ^ 32'h1357_9BDF;
  endfunction

  function automatic logic [255:0] line_data(input logic [31:0] a);
    logic [255:0] d;
    logic [31:0]  base;
    base = {a[31:5], 5'b0};
    d = '0;
    for (int i = 0; i < 8; i++) d[32*i +: 32] = mem_word(base + 32'(4 * i));
    return d;
  endfunction

  function automatic void exp_line(input logic [31:0] a, input int lat, input string name);
    exp_t        e;
    logic [31:0] base;
    base     = {a[31:5], 5'b0};
    e.is_unc = 1'b0;
    e.data   = line_data(a);
    e.cyc    = cyc + lat;
    e.name   = name;
    for (int i = 0; i < 8; i++) addr_q.push_back(base + 32'(4 * i));
    sb_q.push_back(e);
  endfunction

  function automatic void exp_unc(input logic [31:0] a, input int lat, input string name);
    exp_t e;
    e.is_unc = 1'b1;
    e.data   = {224'b0, mem_word(a)};
    e.cyc    = cyc + lat;
    e.name   = name;
    addr_q.push_back(a);
    sb_q.push_back(e);
  endfunction

  task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Monitor: every valid pulse pops one expected response.
  task automatic check_resp(input bit is_unc, input logic [255:0] got);
    exp_t e;
    n_cmp++;
    if (sb_q.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected_pulse: kind=%0d at cycle %0d data=%h, none expected", is_unc, cyc, got);
    end else begin
      e = sb_q.pop_front();
      if (e.is_unc !== is_unc || e.data !== got || e.cyc != cyc) begin
        n_fail++;
        $display("FAIL %s: got kind=%0d cyc=%0d data=%h expected kind=%0d cyc=%0d data=%h",
                 e.name, is_unc, cyc, got, e.is_unc, e.cyc, e.data);
      end else begin
        $display("ok   %s: kind=%0d cyc=%0d data=%h", e.name, is_unc, cyc, got);
      end
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (ret_valid)     check_resp(1'b0, ret_data);
      if (uncache_valid) check_resp(1'b1, {224'b0, uncache_inst});
    end
  end

  // Memory model: grant (optionally stalled), respond one cycle after grant.
  initial begin
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = 32'h0;
    forever begin
      @(negedge clk);
      mem_rvalid = 1'b0;
      mem_rdata  = 32'h0;
      if (pend) begin
        mem_rvalid = 1'b1;
        mem_rdata  = mem_word(pend_addr);
        pend       = 1'b0;
        rv_count++;
      end else if (spur_all) begin
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hBAD0_BAD0;
      end
      mem_gnt = 1'b0;
      if (rst) begin
        addr_q.delete();
      end else if (mem_req) begin
        if (addr_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_req: mem_addr=%h at cycle %0d, none expected", mem_addr, cyc);
        end else if (stall_left > 0 && addr_q[0] == stall_addr) begin
          stall_left--;
          chk("stall_addr_hold", mem_addr, addr_q[0]);
        end else begin
          chk("mem_addr", mem_addr, addr_q.pop_front());
          mem_gnt   = 1'b1;
          pend      = 1'b1;
          pend_addr = mem_addr;
        end
      end
    end
  end

  task automatic hold_line(input logic [31:0] a, input string name);
    bit seen;
    seen    = 1'b0;
    rd_addr = a;
    rd_req  = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (ret_valid) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s_timeout: got no ret_valid, required one within 200 cycles", name);
    end
    @(negedge clk);
    rd_req = 1'b0;
  endtask

  task automatic hold_unc(input logic [31:0] a, input string name);
    bit seen;
    seen         = 1'b0;
    uncache_addr = a;
    uncache_en   = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (uncache_valid) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s_timeout: got no uncache_valid, required one within 200 cycles", name);
    end
    @(negedge clk);
    uncache_en = 1'b0;
  endtask

  task automatic run_line(input logic [31:0] a, input int lat, input string name);
    @(negedge clk);
    exp_line(a, lat, name);
    hold_line(a, name);
  endtask

  task automatic run_unc(input logic [31:0] a, input int lat, input string name);
    @(negedge clk);
    exp_unc(a, lat, name);
    hold_unc(a, name);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ret_valid"},     ret_valid,     '0);
    chk({tag, "_uncache_valid"}, uncache_valid, '0);
    chk({tag, "_mem_req"},       mem_req,       '0);
    chk({tag, "_mem_addr"},      mem_addr,      '0);
    chk({tag, "_ret_data"},      ret_data,      '0);
    chk({tag, "_uncache_inst"},  uncache_inst,  '0);
  endtask

  initial begin
    int start_rv;
    bit reached;
    rst          = 1'b1;
    rd_req       = 1'b0;
    rd_addr      = 32'h0;
    uncache_en   = 1'b0;
    uncache_addr = 32'h0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk_reset_outputs("reset");

    // Ideal memory line fill
    run_line(32'h1C00_0034, 17, "line_ideal");

    // Three grant stalls on word 5
    @(negedge clk);
    stall_addr = 32'h1C00_0054;
    stall_left = 3;
    exp_line(32'h1C00_0040, 20, "line_stall");
    hold_line(32'h1C00_0040, "line_stall");

    // Simultaneous line and uncached requests: line first
    @(negedge clk);
    exp_line(32'h1C00_0080, 17, "simul_line");
    exp_unc(32'h1FD0_0000, 21, "simul_unc");
    fork
      hold_line(32'h1C00_0080, "simul_line");
      hold_unc(32'h1FD0_0000, "simul_unc");
    join

    // Standalone uncached read
    run_unc(32'h1FD0_0010, 3, "unc_alone");

    // Back-to-back fills; held rd_req must not cause a third
    run_line(32'h0000_0000, 17, "b2b_0");
    run_line(32'h0000_0020, 17, "b2b_1");
    repeat (4) @(negedge clk);
    chk("b2b_no_dup_mem_req", mem_req, '0);

    // Spurious responses in IDLE must not disturb the returned line
    spur_all = 1'b1;
    repeat (4) @(negedge clk);
    chk("spur_idle_ret_data", ret_data, line_data(32'h0000_0020));
    run_line(32'h1C00_1000, 17, "spur_line");
    spur_all = 1'b0;

    // Reset after word 3 of a fill, stale responses afterwards
    @(negedge clk);
    for (int i = 0; i < 8; i++) addr_q.push_back(32'h0000_1040 + 32'(4 * i));
    start_rv = rv_count;
    rd_addr  = 32'h0000_1040;
    rd_req   = 1'b1;
    reached  = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      #1;
      if (rv_count >= start_rv + 4) begin
        reached = 1'b1;
        break;
      end
    end
    if (!reached) begin
      n_cmp++;
      n_fail++;
      $display("FAIL midfill_timeout: got %0d responses, required 4", rv_count - start_rv);
    end
    @(negedge clk);
    rst      = 1'b1;
    rd_req   = 1'b0;
    spur_all = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk_reset_outputs("midfill_reset");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("post_reset_mem_req", mem_req, '0);
      chk("post_reset_ret_valid", ret_valid, '0);
    end
    spur_all = 1'b0;
    run_line(32'h0000_1040, 17, "refill_after_reset");

    repeat (5) @(negedge clk);
    n_cmp++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: got %0d responses outstanding, required 0", sb_q.size());
    end
    n_cmp++;
    if (addr_q.size() != 0) begin
      n_fail++;
      $display("FAIL addr_drain: got %0d requests outstanding, required 0", addr_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/line_fill_responder.md
# line_fill_responder

Memory-side responder for the instruction-cache refill interface. Accepts a line request (`rd_req`/`rd_addr`) or an uncached single-word request (`uncache_en`/`uncache_addr`) from the icache. It issues sequential 32-bit reads on a word-wide request/grant/response memory port, assembles the words into a 256-bit line, and returns it with a one-cycle `ret_valid` (or `uncache_valid`) pulse. It sits between `icache` and the backing instruction memory, in place of a line-wide ROM.

## Interface
Parameters:
- `LINE_WORDS`, 8: words per cache line; fixed by the 256-bit `ret_data`.
- `ADDR_W`, 32: address width.

Ports:
- `clk`  in  1  sole clock.
- `rst`  in  1  synchronous reset, active-high.
- `rd_req`  in  1  line refill request, held by requester until `ret_valid`.
- `rd_addr`  in  32  refill address; bits [4:0] ignored.
- `ret_valid`  out  1  one-cycle pulse: `ret_data` holds the complete line.
- `ret_data`  out  256  line; word i at `[32*i +: 32]` = mem[base + 4*i].
- `uncache_en`  in  1  uncached word request, held until `uncache_valid`.
- `uncache_addr`  in  32  uncached word address (word-aligned).
- `uncache_valid`  out  1  one-cycle pulse: `uncache_inst` is valid.
- `uncache_inst`  out  32  uncached word.
- `mem_req`  out  1  memory read request.
- `mem_addr`  out  32  word address of the current request.
- `mem_gnt`  in  1  memory accepts the request this cycle.
- `mem_rvalid`  in  1  read data valid.
- `mem_rdata`  in  32  read data.

## Operation
- States: IDLE, L_REQ, L_WAIT, L_RESP, U_REQ, U_WAIT, U_RESP.
- IDLE:
  - `rd_req` → latch base = {`rd_addr`[31:5], 5'b0}, clear the 3-bit word counter `cnt`, go to L_REQ.
  - else `uncache_en` → latch `uncache_addr`, go to U_REQ.
  - If both are asserted, the line request wins; `uncache_en` stays pending and is served after returning to IDLE.
- L_REQ:
  - `mem_req`=1, `mem_addr` = base + 4*`cnt`.
  - `mem_gnt` → L_WAIT; otherwise stay.
- L_WAIT:
  - On `mem_rvalid`, write `mem_rdata` into fill-buffer word `cnt`.
  - If `cnt`==7 → L_RESP; else `cnt`+1 → L_REQ.
- L_RESP: `ret_valid`=1 for one cycle, `ret_data` = fill buffer, then IDLE.
- U_REQ / U_WAIT: same handshake with the latched address. On `mem_rvalid`, register the data → U_RESP.
- U_RESP: `uncache_valid`=1 for one cycle, then IDLE.
- Only one memory request is outstanding at any time; `mem_req` is deasserted outside L_REQ/U_REQ.
- `mem_rvalid` outside L_WAIT/U_WAIT is ignored. This covers stale responses after reset.
- Requests are sampled only in IDLE. The requester must drop `rd_req`/`uncache_en` in the cycle after the valid pulse; the block re-samples in that cycle.
- `cnt` is 3 bits and must not wrap within a line: the exit is at 7. Address arithmetic is modulo 2^32, with no carry into bits [31:5].

## Timing
- Reset values: state IDLE, `cnt`=0, `ret_valid`=0, `uncache_valid`=0, `mem_req`=0, `mem_addr`=0, `ret_data`=0, `uncache_inst`=0.
- Reset mid-fill: return to IDLE next cycle with the fill buffer cleared; no valid pulse is produced.
- `ret_data` and `uncache_inst` are registered. They hold their last value until the next completion.
- Best case (`mem_gnt`=1 always, `mem_rvalid` one cycle after grant), request seen in IDLE at cycle 0:
  - line: `ret_valid` at cycle 17 (2 cycles per word plus 1).
  - uncached: `uncache_valid` at cycle 3.
- Each grant stall or response delay adds one cycle per occurrence.

## Structure
- Add to `pipeline_types`: the `fill_state_t` enum, `LINE_WORDS`, and `LINE_OFFSET_W`=5. Reuse `bus32_t` and `bus256_t` from the package.
- Single module with no sub-module; the fill buffer is an inline 8×32 register array.
- Instantiated in `cpu_spoc` between `icache_mem_io` and the word-wide instruction memory.

## Test plan
- Line fill, ideal memory: `rd_req` with `rd_addr`=0x1C00_0034 → `mem_addr` sequence 0x1C00_0020…0x1C00_003C, `ret_valid` at cycle 17, `ret_data` word i = mem[0x1C00_0020 + 4i].
- Grant stalls: `mem_gnt` low for 3 cycles on word 5 → same data, `ret_valid` at cycle 20, `mem_addr` held at base+0x14 throughout the stall.
- Simultaneous requests: `rd_req` and `uncache_en` (0x1FD0_0000) asserted in the same cycle → line served first; uncached `mem_req` appears after `ret_valid`; `uncache_valid` pulses with mem[0x1FD0_0000].
- Reset mid-fill: assert `rst` after word 3, inject a stale `mem_rvalid` after reset → no `ret_valid`, state IDLE, all outputs at reset values, the next fill's data is correct.
- Back-to-back fills at 0x0 and 0x20 → two `ret_valid` pulses, with no duplicate fill caused by the held `rd_req`.
- Spurious `mem_rvalid` in IDLE/L_REQ → ignored, fill buffer unchanged.
